axi4_lite_burst_master: RTL
===========================

// Module: axi4_lite_burst_master
// PURPOSE
//  Parametrised AXI4-Lite master, successor to the single-beat bridge master.
//  Takes one command (cmd/addr/write buffer) and executes 1..MAX_BEATS sequential single-beat AXI4-Lite transfers.
//  Supports 8/16/32/64-bit access sizes on a DATA_WIDTH bus, incrementing or fixed address, and per-handshake timeout.
//  Sits between the UART frame parser and the register/peripheral AXI4-Lite fabric.
// PARAMETERS
//  ADDR_WIDTH      32    AXI address width
//  DATA_WIDTH      32    AXI data width; 32 or 64
//  MAX_BEATS       16    max beats per command; power of 2, <=16
//  TIMEOUT_CYCLES  1024  max cycles waiting for any single handshake
//  MAX_BYTES       MAX_BEATS*DATA_WIDTH/8 (localparam) byte capacity of each data buffer
// PORTS
//  clk               in   1               clock
//  rst_n             in   1               async active-low reset
//  cmd               in   8               [7]=rw (1=read); [6]=fixed addr; [5:4]=size (0:1B,1:2B,2:4B,3:8B); [3:0]=beats-1
//  addr              in   ADDR_WIDTH      start byte address
//  write_data        in   8*MAX_BYTES     packed bytes; beat n uses bytes [n*S +: S], S=1<<size, LSB byte first
//  start_transaction in   1               one-cycle request; sampled only in IDLE
//  busy              out  1               high from accepted start until done pulse
//  transaction_done  out  1               one-cycle completion pulse
//  axi_status        out  8               0x00 OK, 0x01 SLVERR, 0x02 DECERR, 0x03 misaligned, 0x04 size>bus, 0x05 timeout, 0x06 4KB cross
//  read_data         out  8*MAX_BYTES     packed read bytes, same layout as write_data
//  read_data_count   out  $clog2(MAX_BYTES)+1  bytes of valid read_data
//  m_axi_aw*/w*/b*/ar*/r*  standard AXI4-Lite master signals; awprot/arprot tied 3'b000
// BEHAVIOUR
//  Reset (async, rst_n=0): all AXI valids/readies 0, busy 0, done 0, axi_status 0x00, read_data_count 0, read_data 0, FSM IDLE.
//    Takes effect mid-burst, no completion of the outstanding handshake.
//  FSM: IDLE -> CHECK -> (W_ADDR_DATA -> W_RESP | R_ADDR -> R_DATA) -> NEXT -> ... -> DONE -> IDLE.
//  IDLE: on start_transaction latch cmd/addr/write_data, clear read_data_count, busy=1 next cycle.
//    start while busy is ignored.
//  CHECK (1 cycle), first failing rule wins, then DONE with zero bus activity:
//    S>DATA_WIDTH/8 -> 0x04; addr%S!=0 -> 0x03; incrementing and addr[11:0]+beats*S>4096 -> 0x06.
//  W_ADDR_DATA: awvalid and wvalid asserted together. Each drops independently on its own handshake; -> W_RESP when both done.
//    awaddr=current addr; wdata = beat bytes shifted to lane addr[$clog2(DW/8)-1:0]; wstrb = S ones at the same lane.
//  W_RESP: bready=1; on bvalid record bresp.
//  R_ADDR: arvalid until arready. R_DATA: rready=1; on rvalid extract S bytes from lane, append at byte offset n*S.
//    read_data_count += S on OKAY only.
//  NEXT: bresp/rresp!=OKAY -> status 0x01/0x02, stop burst, -> DONE. Last beat -> DONE.
//    Otherwise addr += S (unless fixed), beat++ and reissue.
//  Timeout: counter clears on each state entry; TIMEOUT_CYCLES in a waiting state -> drop all valids/readies, status 0x05, -> DONE.
//  DONE: transaction_done=1 for exactly one cycle; busy falls the same cycle; axi_status/read_data hold until next accepted start.
//  Latency (zero-wait slave, 1 beat): start -> done = 5 cycles write, 5 cycles read. Each extra beat adds 3 cycles.
//  Valid never deasserts before its ready (AXI rule); no combinational path from any ready to any valid.
// TESTING
//  1. DW=32: write cmd 0x20 addr 0x1020 bytes 78 56 34 12 -> one AW/W, wdata 0x12345678, wstrb 0xF, status 0x00.
//     Then read 0xA0 -> count 4, bytes 78 56 34 12.
//  2. Burst: write cmd 0x23 addr 0x1020, 16 bytes -> 4 AW at 0x1020/24/28/2C.
//     Then read 0xA3 -> count 16, data matches.
//  3. Byte access: cmd 0x00 addr 0x1023 data 0xAB -> wdata 0xAB000000, wstrb 0x8; fixed-addr read 0xC1 -> 2 AR both at 0x1023.
//  4. Errors: addr 0x1022 size 2 -> 0x03, no AW. Size 3 on DW=32 -> 0x04. 0xA3 at 0x1FF8 -> 0x06.
//     Slave DECERR on beat 2 of 4 -> status 0x02, count 4, stop.
//  5. Timeout: slave never asserts awready -> done after TIMEOUT_CYCLES+~3, status 0x05, awvalid low.
//     Next command completes normally.
//  6. Backpressure/reset: random ready delays 0..7 with awready/wready skewed -> data intact.
//     rst_n low mid-R_DATA -> all outputs at reset values immediately.

Source files
------------

// File: rtl/axi4_lite_burst_master.sv
// AXI4-Lite burst master: executes one command as 1..MAX_BEATS sequential
// single-beat AXI4-Lite transfers of 1/2/4/8 bytes, with incrementing or
// fixed addressing, legality checks up front and a per-handshake timeout.
module axi4_lite_burst_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_BEATS      = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int MAX_BYTES     = MAX_BEATS * DATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    cmd,
    input  logic [ADDR_WIDTH-1:0]         addr,
    input  logic [8*MAX_BYTES-1:0]        write_data,
    input  logic                          start_transaction,
    output logic                          busy,
    output logic                          transaction_done,
    output logic [7:0]                    axi_status,
    output logic [8*MAX_BYTES-1:0]        read_data,
    output logic [$clog2(MAX_BYTES):0]    read_data_count,
    output logic [ADDR_WIDTH-1:0]         m_axi_awaddr,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [DATA_WIDTH-1:0]         m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]       m_axi_wstrb,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
    output logic [2:0]                    m_axi_arprot,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    localparam int SB     = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(SB);
    localparam int BUF_W  = 8 * MAX_BYTES;
    localparam int CNT_W  = $clog2(MAX_BYTES) + 1;
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_SLVERR   = 8'h01;
    localparam logic [7:0] ST_DECERR   = 8'h02;
    localparam logic [7:0] ST_MISALIGN = 8'h03;
    localparam logic [7:0] ST_SIZE     = 8'h04;
    localparam logic [7:0] ST_TIMEOUT  = 8'h05;
    localparam logic [7:0] ST_4K       = 8'h06;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_W_AD, S_W_RESP, S_R_ADDR, S_R_DATA, S_NEXT, S_DONE
    } state_t;

    state_t state, state_n;

    // Command fields captured at start; plain data, no reset needed
    logic                  rw_q;
    logic                  fixed_q;
    logic [1:0]            size_q;
    logic [3:0]            beats_m1_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BUF_W-1:0]      wbuf_q;
    logic [1:0]            resp_q;

    // Burst progress and handshake bookkeeping
    logic [3:0]            beat_q;
    logic [CNT_W-1:0]      off_q;
    logic                  aw_done;
    logic                  w_done;
    logic [TMO_W-1:0]      tmo_cnt;

    logic [3:0]            sbytes;
    logic [7:0]            span;
    logic [LANE_W-1:0]     lane;
    logic [SB-1:0]         strb_base;
    logic [DATA_WIDTH-1:0] dmask;
    logic [DATA_WIDTH-1:0] rext;
    logic [7:0]            chk_status;
    logic                  tmo_last;
    logic                  tmo_fire;
    logic                  last_beat;
    logic                  resp_err;

    assign sbytes    = 4'd1 << size_q;
    assign span      = ({4'd0, beats_m1_q} + 8'd1) << size_q;
    assign lane      = addr_q[LANE_W-1:0];
    assign tmo_last  = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign last_beat = (beat_q == beats_m1_q);
    assign resp_err  = (resp_q != 2'b00);

    // Byte-enable and data mask for one access of the current size, lane 0
    always_comb begin
        strb_base = '0;
        dmask     = '0;
        for (int i = 0; i < SB; i++) begin
            if (i < int'(sbytes)) begin
                strb_base[i]      = 1'b1;
                dmask[i*8 +: 8]   = 8'hFF;
            end
        end
    end

    // Legality of the whole command; first failing rule decides the status
    always_comb begin
        chk_status = ST_OK;
        if (int'(size_q) > LANE_W)
            chk_status = ST_SIZE;
        else if ((addr_q[3:0] & (sbytes - 4'd1)) != 4'd0)
            chk_status = ST_MISALIGN;
        else if (!fixed_q && (({1'b0, addr_q[11:0]} + {5'd0, span}) > 13'd4096))
            chk_status = ST_4K;
    end

    // Lane placement of write data and extraction of read data
    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wdata  = (DATA_WIDTH'(wbuf_q >> {off_q, 3'b000}) & dmask) << {lane, 3'b000};
    assign m_axi_wstrb  = strb_base << lane;
    assign rext         = (m_axi_rdata >> {lane, 3'b000}) & dmask;

    // Next-state and bus outputs; valids depend only on registered state
    always_comb begin
        state_n          = state;
        m_axi_awvalid    = 1'b0;
        m_axi_wvalid     = 1'b0;
        m_axi_bready     = 1'b0;
        m_axi_arvalid    = 1'b0;
        m_axi_rready     = 1'b0;
        busy             = 1'b1;
        transaction_done = 1'b0;
        tmo_fire         = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start_transaction) state_n = S_CHECK;
            end
            S_CHECK: begin
                if (chk_status != ST_OK) state_n = S_DONE;
                else if (rw_q)           state_n = S_R_ADDR;
                else                     state_n = S_W_AD;
            end
            S_W_AD: begin
                m_axi_awvalid = !aw_done;
                m_axi_wvalid  = !w_done;
                if ((aw_done || m_axi_awready) && (w_done || m_axi_wready))
                    state_n = S_W_RESP;
                else if (tmo_last) begin
                    tmo_fire = 1'b1;
                    state_n  = S_DONE;
                end
            end
            S_W_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_n = S_NEXT;
                else if (tmo_last) begin
                    tmo_fire = 1'b1;
                    state_n  = S_DONE;
                end
            end
            S_R_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_n = S_R_DATA;
                else if (tmo_last) begin
                    tmo_fire = 1'b1;
                    state_n  = S_DONE;
                end
            end
            S_R_DATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) state_n = S_NEXT;
                else if (tmo_last) begin
                    tmo_fire = 1'b1;
                    state_n  = S_DONE;
                end
            end
            S_NEXT: begin
                if (resp_err || last_beat) state_n = S_DONE;
                else if (rw_q)             state_n = S_R_ADDR;
                else                       state_n = S_W_AD;
            end
            S_DONE: begin
                busy             = 1'b0;
                transaction_done = 1'b1;
                state_n          = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Control state: FSM, handshake flags, timeout, status and read buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            tmo_cnt         <= '0;
            beat_q          <= '0;
            off_q           <= '0;
            axi_status      <= ST_OK;
            read_data_count <= '0;
            read_data       <= '0;
        end else begin
            state   <= state_n;
            tmo_cnt <= (state_n != state) ? '0 : tmo_cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    if (start_transaction) begin
                        aw_done         <= 1'b0;
                        w_done          <= 1'b0;
                        beat_q          <= '0;
                        off_q           <= '0;
                        axi_status      <= ST_OK;
                        read_data_count <= '0;
                        read_data       <= '0;
                    end
                end
                S_CHECK: axi_status <= chk_status;
                S_W_AD: begin
                    if (m_axi_awvalid && m_axi_awready) aw_done <= 1'b1;
                    if (m_axi_wvalid && m_axi_wready)   w_done  <= 1'b1;
                end
                S_R_DATA: begin
                    if (m_axi_rvalid && m_axi_rresp == 2'b00) begin
                        read_data       <= read_data | (BUF_W'(rext) << {off_q, 3'b000});
                        read_data_count <= read_data_count + CNT_W'(sbytes);
                    end
                end
                S_NEXT: begin
                    if (resp_err)
                        axi_status <= (resp_q == 2'b11) ? ST_DECERR : ST_SLVERR;
                    else if (!last_beat) begin
                        beat_q  <= beat_q + 4'd1;
                        off_q   <= off_q + CNT_W'(sbytes);
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (tmo_fire) axi_status <= ST_TIMEOUT;
        end
    end

    // Command capture, response capture and address stepping
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start_transaction) begin
            rw_q       <= cmd[7];
            fixed_q    <= cmd[6];
            size_q     <= cmd[5:4];
            beats_m1_q <= cmd[3:0] & 4'(MAX_BEATS - 1);
            addr_q     <= addr;
            wbuf_q     <= write_data;
        end
        if (state == S_W_RESP && m_axi_bvalid) resp_q <= m_axi_bresp;
        if (state == S_R_DATA && m_axi_rvalid) resp_q <= m_axi_rresp;
        if (state == S_NEXT && !resp_err && !last_beat && !fixed_q)
            addr_q <= addr_q + ADDR_WIDTH'(sbytes);
    end

endmodule
